dds_phase_accumulator: RTL and testbench
========================================

# dds_phase_accumulator

Phase-accumulator stage of the DDS datapath, directly upstream of the waveform lookup ROMs. It accumulates a frequency tuning word (FTW) at a programmable sample rate, adds a phase offset, and drives the 10-bit ROM address. It also produces a validity strobe delayed to match the ROM's one-cycle registered read latency. FTW updates arrive over a valid/ready handshake and are applied glitch-free on a sample boundary.

## Interface
- `ACC_WIDTH`, 32: accumulator width.
- `ADDR_WIDTH`, 10: ROM address width; `ACC_WIDTH - ADDR_WIDTH` must be ≥ 16.
- `DIV_WIDTH`, 16: sample-rate divider width.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: run/hold.
- `phase_clear`  in  1: zero accumulator and divider.
- `clk_div`  in  DIV_WIDTH: tick period minus one.
- `phase_offset`  in  ADDR_WIDTH: added to truncated phase.
- `ftw_in`  in  ACC_WIDTH: new tuning word.
- `ftw_valid`  in  1: `ftw_in` offered.
- `ftw_ready`  out  1: pending slot empty.
- `addr`  out  ADDR_WIDTH: ROM address.
- `addr_valid`  out  1: one-cycle strobe, `addr` is new.
- `sample_valid`  out  1: `addr_valid` delayed 1 cycle; ROM output valid.
- `wrap`  out  1: accumulator carry-out on this sample, aligned with `addr_valid`.

## Operation
- Reset values:
  - `acc` = 0, `ftw_active` = 0, pending empty.
  - `ftw_ready` = 1.
  - `addr` = 0; `addr_valid`, `sample_valid`, `wrap` = 0.
  - `div_cnt` = 0; state = IDLE.
- States:
  - IDLE → RUN when `enable` = 1.
  - RUN → IDLE when `enable` = 0.
  - Transitions take effect on the next edge.
- Divider:
  - In IDLE, `div_cnt` is held at 0.
  - In RUN, a tick occurs when `div_cnt >= clk_div`; `div_cnt` then goes to 0, otherwise it increments.
  - `clk_div` = 0 gives a tick every RUN cycle. Lowering `clk_div` below `div_cnt` forces an immediate tick.
- On a tick:
  - `acc_next = acc + ftw_active` mod 2^ACC_WIDTH; `acc <= acc_next`.
  - `addr <= acc_next[top ADDR_WIDTH bits] + phase_offset` mod 2^ADDR_WIDTH.
  - `addr_valid <= 1`; `wrap <= carry-out`. In all other cycles `addr_valid` and `wrap` are 0.
- FTW handshake:
  - A transfer occurs when `ftw_valid && ftw_ready`: the word is stored in pending, and `ftw_ready` is 0 from the next cycle.
  - RUN: pending moves to `ftw_active` on the next tick. That tick still adds the old `ftw_active`, so the new word first affects the following tick. `ftw_ready` returns to 1 the cycle after the move.
  - IDLE: pending moves to `ftw_active` on the next edge.
- `phase_clear`:
  - Next edge: `acc` = 0, `div_cnt` = 0, no tick, `addr_valid` = 0.
  - Overrides a coincident tick. Pending FTW and `addr` are unaffected.
- Disable mid-run: `acc`, `addr` and `ftw_active` are retained, and resuming continues from the retained phase.
- `reset` overrides everything, including a handshake in progress.

## Timing
- Tick evaluated in cycle n → `addr` and `addr_valid` at n+1 → ROM data and `sample_valid` at n+2.
- `sample_valid` = `addr_valid` registered, in all states.
- All outputs are registered; there is no combinational input-to-output path except `ftw_ready`, which is a register.

## Configuration
- `DDS_PHASE_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances once per tick.
  - On a tick, `addr` is taken from `acc_next + (lfsr << (ACC_WIDTH-ADDR_WIDTH-16))` mod 2^ACC_WIDTH, then `phase_offset` is added.
  - Dither affects `addr` only; it is never stored in `acc` and never affects `wrap`.
- Undefined: no LFSR is instantiated, and `addr` is pure truncation.

## Test plan
- Reset; `ftw` = 0x00400000, `clk_div` = 0, `enable` = 1 → `addr` = 1, 2, 3… every cycle. After 1024 ticks, `addr` = 0 with `wrap` = 1. `sample_valid` lags `addr_valid` by 1 cycle.
- `ftw` = 0x01000000, `clk_div` = 3 → `addr_valid` one cycle in four, `addr` = 4, 8, 12…
- Running at `ftw` = 0x00400000, offer 0x00800000 → `ftw_ready` drops. The next tick still steps by 1, and subsequent ticks step by 2. `ftw_ready` rises the cycle after the apply tick.
- `ftw` = 0, `phase_offset` = 512 → every tick `addr` = 512, `wrap` = 0.
- `phase_clear` coincident with a tick at `addr` = 37 → no `addr_valid` that cycle. With `ftw` = 0x00400000 and `phase_offset` = 0, the next tick gives `addr` = 1.
- `enable` dropped at `addr` = 100 for 10 cycles → no strobes and `addr` holds 100. Re-enable → next `addr` = 101 (dither macro undefined).

Source files
------------

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: tuning-word accumulation at a divided sample rate,
// phase offset, and ROM address/strobe generation. Optional dither: DDS_PHASE_DITHER_EN.
module dds_phase_accumulator #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  phase_clear,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [ADDR_WIDTH-1:0] phase_offset,
  input  logic [ACC_WIDTH-1:0]  ftw_in,
  input  logic                  ftw_valid,
  output logic                  ftw_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  output logic                  sample_valid,
  output logic                  wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_reg, state_next;

  logic [ACC_WIDTH-1:0]  acc_reg;
  logic [ACC_WIDTH-1:0]  ftw_active_reg;
  logic [ACC_WIDTH-1:0]  pending_reg;
  logic                  pending_valid_reg;
  logic                  pending_valid_next;
  logic                  ftw_ready_reg;
  logic [DIV_WIDTH-1:0]  div_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  addr_valid_reg;
  logic                  sample_valid_reg;
  logic                  wrap_reg;

  logic [ACC_WIDTH:0]    acc_sum;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  acc_carry;
  logic [ADDR_WIDTH-1:0] phase_sel;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  tick_raw;
  logic                  tick;
  logic                  ftw_take;
  logic                  ftw_load;

  // Run/hold FSM
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable)  state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A clear suppresses the tick entirely, including the pending-word move.
  assign tick_raw = (state_reg == RUN) && (div_cnt_reg >= clk_div);
  assign tick     = tick_raw && !phase_clear;

  assign acc_sum   = {1'b0, acc_reg} + {1'b0, ftw_active_reg};
  assign acc_next  = acc_sum[ACC_WIDTH-1:0];
  assign acc_carry = acc_sum[ACC_WIDTH];

  assign ftw_take = ftw_valid && ftw_ready_reg;
  assign ftw_load = pending_valid_reg && ((state_reg == IDLE) || tick);

  always_comb begin
    pending_valid_next = pending_valid_reg;
    if (ftw_take)      pending_valid_next = 1'b1;
    else if (ftw_load) pending_valid_next = 1'b0;
  end

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITHER_SHIFT = ACC_WIDTH - ADDR_WIDTH - 16;

  logic [15:0]          lfsr_reg;
  logic                 lfsr_fb;
  logic [ACC_WIDTH-1:0] dither_phase;

  // x^16 + x^14 + x^13 + x^11 + 1
  assign lfsr_fb      = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign dither_phase = acc_next + (ACC_WIDTH'(lfsr_reg) << DITHER_SHIFT);
  assign phase_sel    = dither_phase[ACC_WIDTH-1 -: ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (reset)     lfsr_reg <= 16'hACE1;
    else if (tick) lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
  end
`else
  assign phase_sel = acc_next[ACC_WIDTH-1 -: ADDR_WIDTH];
`endif

  assign addr_next = phase_sel + phase_offset;

  // Datapath, divider and FTW handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_reg           <= '0;
      ftw_active_reg    <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      ftw_ready_reg     <= 1'b1;
      div_cnt_reg       <= '0;
      addr_reg          <= '0;
      addr_valid_reg    <= 1'b0;
      sample_valid_reg  <= 1'b0;
      wrap_reg          <= 1'b0;
    end else begin
      pending_valid_reg <= pending_valid_next;
      ftw_ready_reg     <= !pending_valid_next;
      if (ftw_take) pending_reg    <= ftw_in;
      if (ftw_load) ftw_active_reg <= pending_reg;

      addr_valid_reg   <= tick;
      wrap_reg         <= tick && acc_carry;
      sample_valid_reg <= addr_valid_reg;

      if (phase_clear) begin
        acc_reg     <= '0;
        div_cnt_reg <= '0;
      end else if (tick) begin
        acc_reg     <= acc_next;
        addr_reg    <= addr_next;
        div_cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        div_cnt_reg <= div_cnt_reg + DIV_WIDTH'(1);
      end else begin
        div_cnt_reg <= '0;
      end
    end
  end

  assign ftw_ready    = ftw_ready_reg;
  assign addr         = addr_reg;
  assign addr_valid   = addr_valid_reg;
  assign sample_valid = sample_valid_reg;
  assign wrap         = wrap_reg;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed self-checking bench for dds_phase_accumulator (dither macro undefined).
module tb_dds_phase_accumulator;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        phase_clear;
  logic [15:0] clk_div;
  logic [9:0]  phase_offset;
  logic [31:0] ftw_in;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [9:0]  addr;
  logic        addr_valid;
  logic        sample_valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  dds_phase_accumulator dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .phase_clear  (phase_clear),
    .clk_div      (clk_div),
    .phase_offset (phase_offset),
    .ftw_in       (ftw_in),
    .ftw_valid    (ftw_valid),
    .ftw_ready    (ftw_ready),
    .addr         (addr),
    .addr_valid   (addr_valid),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset, load a tuning word while idle, then enable (state enters RUN).
  task automatic start_run(input logic [31:0] ftw, input logic [15:0] div,
                           input logic [9:0] off);
    reset = 1'b1; enable = 1'b0; phase_clear = 1'b0; ftw_valid = 1'b0;
    ftw_in = '0; clk_div = '0; phase_offset = '0;
    step(); step();
    reset = 1'b0;
    ftw_in = ftw; ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    step();
    clk_div = div; phase_offset = off; enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; phase_clear = 1'b0; ftw_valid = 1'b1;
    ftw_in = 32'h1234_5678; clk_div = '0; phase_offset = 10'd5;
    step(); step();
    checks++;
    if ({ftw_ready, addr_valid, sample_valid, wrap} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 1000", {ftw_ready, addr_valid, sample_valid, wrap});
    end
    checks++;
    if (addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d expected 0", addr);
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic_sweep();
    logic [12:0] got, exp;
    start_run(32'h0040_0000, 16'd0, 10'd0);
    for (int i = 1; i <= 1024; i++) begin
      step();
      got = {addr_valid, wrap, sample_valid, addr};
      exp = {1'b1, (i == 1024), (i > 1), 10'(i % 1024)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sweep_tick%0d: got %h expected %h", i, got, exp);
      end
    end
    $display("test_basic_sweep: 1024 ticks");
  endtask

  task automatic test_divider();
    start_run(32'h0100_0000, 16'd3, 10'd0);
    for (int j = 1; j <= 16; j++) begin
      step();
      checks++;
      if ({addr_valid, addr} !== {(j % 4 == 0), 10'(4 * (j / 4))}) begin
        errors++;
        $display("FAIL div4_cycle%0d: got v=%b a=%0d expected v=%b a=%0d",
                 j, addr_valid, addr, (j % 4 == 0), 4 * (j / 4));
      end
    end
    $display("test_divider: 16 cycles");
  endtask

  task automatic test_div_lower();
    start_run(32'h0040_0000, 16'd7, 10'd0);
    for (int j = 0; j < 5; j++) begin
      step();
      checks++;
      if (addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL divlow_quiet%0d: got %b expected 0", j, addr_valid);
      end
    end
    clk_div = 16'd2;
    step();
    checks++;
    if ({addr_valid, addr} !== {1'b1, 10'd1}) begin
      errors++;
      $display("FAIL divlow_forced: got v=%b a=%0d expected v=1 a=1", addr_valid, addr);
    end
    step(); step(); step();
    checks++;
    if ({addr_valid, addr} !== {1'b1, 10'd2}) begin
      errors++;
      $display("FAIL divlow_next: got v=%b a=%0d expected v=1 a=2", addr_valid, addr);
    end
    $display("test_div_lower: done");
  endtask

  task automatic test_ftw_update();
    int exp_addr;
    start_run(32'h0040_0000, 16'd0, 10'd0);
    for (int j = 0; j < 5; j++) step();
    ftw_in = 32'h0080_0000; ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    $display("test_ftw_update: offered 00800000");
    checks++;
    if ({ftw_ready, addr} !== {1'b0, 10'd6}) begin
      errors++;
      $display("FAIL ftw_transfer: got rdy=%b a=%0d expected rdy=0 a=6", ftw_ready, addr);
    end
    step();
    checks++;
    if ({ftw_ready, addr} !== {1'b1, 10'd7}) begin
      errors++;
      $display("FAIL ftw_apply_tick: got rdy=%b a=%0d expected rdy=1 a=7", ftw_ready, addr);
    end
    exp_addr = 7;
    for (int j = 0; j < 3; j++) begin
      step();
      exp_addr += 2;
      checks++;
      if (addr !== 10'(exp_addr)) begin
        errors++;
        $display("FAIL ftw_new_step%0d: got %0d expected %0d", j, addr, exp_addr);
      end
    end
  endtask

  task automatic test_offset();
    start_run(32'h0, 16'd0, 10'd512);
    for (int j = 0; j < 4; j++) begin
      step();
      checks++;
      if ({addr_valid, wrap, addr} !== {1'b1, 1'b0, 10'd512}) begin
        errors++;
        $display("FAIL offset_tick%0d: got v=%b w=%b a=%0d expected v=1 w=0 a=512",
                 j, addr_valid, wrap, addr);
      end
    end
    $display("test_offset: done");
  endtask

  task automatic test_phase_clear();
    start_run(32'h0040_0000, 16'd0, 10'd0);
    for (int j = 0; j < 37; j++) step();
    checks++;
    if (addr !== 10'd37) begin
      errors++;
      $display("FAIL clear_pre: got %0d expected 37", addr);
    end
    phase_clear = 1'b1;
    step();
    phase_clear = 1'b0;
    checks++;
    if ({addr_valid, sample_valid, addr} !== {1'b0, 1'b1, 10'd37}) begin
      errors++;
      $display("FAIL clear_cycle: got v=%b sv=%b a=%0d expected v=0 sv=1 a=37",
               addr_valid, sample_valid, addr);
    end
    step();
    checks++;
    if ({addr_valid, sample_valid, addr} !== {1'b1, 1'b0, 10'd1}) begin
      errors++;
      $display("FAIL clear_after: got v=%b sv=%b a=%0d expected v=1 sv=0 a=1",
               addr_valid, sample_valid, addr);
    end
    $display("test_phase_clear: done");
  endtask

  task automatic test_disable();
    start_run(32'h0040_0000, 16'd0, 10'd0);
    for (int j = 0; j < 99; j++) step();
    enable = 1'b0;
    step();
    checks++;
    if ({addr_valid, addr} !== {1'b1, 10'd100}) begin
      errors++;
      $display("FAIL disable_last: got v=%b a=%0d expected v=1 a=100", addr_valid, addr);
    end
    for (int j = 0; j < 10; j++) begin
      step();
      checks++;
      if ({addr_valid, sample_valid, addr} !== {1'b0, (j == 0), 10'd100}) begin
        errors++;
        $display("FAIL disable_hold%0d: got v=%b sv=%b a=%0d expected v=0 sv=%b a=100",
                 j, addr_valid, sample_valid, addr, (j == 0));
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL resume_enter: got %b expected 0", addr_valid);
    end
    step();
    checks++;
    if ({addr_valid, addr} !== {1'b1, 10'd101}) begin
      errors++;
      $display("FAIL resume_tick: got v=%b a=%0d expected v=1 a=101", addr_valid, addr);
    end
    $display("test_disable: done");
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_divider();
    test_div_lower();
    test_ftw_update();
    test_offset();
    test_phase_clear();
    test_disable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
